flash_cmd_sequencer: RTL
========================

// Module: flash_cmd_sequencer
// PURPOSE
//  Sequences JEDEC word-mode command cycles (program word, sector/chip erase, read-array reset)
//  into the on-board flash and arbitrates the flash bus against the CPU read/overlay path.
//  Sits between the register decode (cmd_*) and the flash pins. It owns WE/OE/DQ while busy
//  and stalls CPU flash cycles until the flash deasserts BUSY.
// PARAMETERS
//  WE_LOW_CYCLES   2         CLKCPU cycles FLASH_WE_n held low per write cycle (>=1)
//  WE_HIGH_CYCLES  2         CLKCPU cycles WE_n high after each pulse (>=1)
//  BUSY_SETTLE     4         cycles after last WE rise before FLASH_BUSY_n is sampled
//  TIMEOUT_W       24        width of poll timeout counter
//  TIMEOUT         24'hFFFFFF poll cycles before error
// PORTS
//  CLKCPU        in   1   CPU clock
//  RESET_n       in   1   reset; synchronous, active-low
//  cmd_valid     in   1   command request; accepted when cmd_valid && cmd_ready
//  cmd_op        in   2   00 program word, 01 sector erase, 10 chip erase, 11 read-array reset
//  cmd_addr      in   19  word address [19:1] (program target / sector address)
//  cmd_data      in   16  program data
//  cmd_ready     out  1   high only in IDLE with cpu_req low
//  busy          out  1   high in every state except IDLE
//  done          out  1   one-cycle pulse on successful completion
//  error         out  1   sticky poll timeout; cleared on next accepted command
//  cpu_req       in   1   CPU flash cycle in progress (decoded flash access with AS active)
//  cpu_grant     out  1   CPU path may drive FLASH_OE_n/WE_n; low whenever busy
//  cpu_wait      out  1   cpu_req && busy; gates CPU DTACK
//  FLASH_BUSY_n  in   1   flash ready/busy, low = busy
//  FLASH_A       out  19  flash word address while busy
//  FLASH_DQ_OUT  out  16  write data
//  FLASH_DQ_OE   out  1   sequencer drives DQ
//  FLASH_WE_n    out  1   sequencer write enable
//  FLASH_OE_n    out  1   sequencer output enable, constant 1 (no status reads)
// BEHAVIOUR
//  Reset: state IDLE; cmd_ready=!cpu_req; busy=done=error=0; cpu_grant=1; FLASH_WE_n=FLASH_OE_n=1;
//   FLASH_DQ_OE=0; FLASH_A=0; FLASH_DQ_OUT=0; all counters 0. Reset mid-operation aborts at once,
//   with no trailing F0 cycle.
//  States: IDLE, SETUP, WE_LO, WE_HI, SETTLE, POLL, DONE, ERR_RST.
//  Cycle lists (addr/data), indexed by a 3-bit step counter:
//   prog : 555/AA 2AA/55 555/A0 cmd_addr/cmd_data                        (4 steps)
//   sect : 555/AA 2AA/55 555/80 555/AA 2AA/55 cmd_addr/0030             (6 steps)
//   chip : 555/AA 2AA/55 555/80 555/AA 2AA/55 555/0010                   (6 steps)
//   rst  : 000/00F0                                                      (1 step, no poll)
//  cmd_addr, cmd_data and cmd_op are latched on acceptance. The inputs are ignored afterwards.
//  IDLE -> SETUP on accept. Acceptance also clears error. No accept while cpu_req=1, and CPU wins ties.
//  SETUP : 1 cycle; A/DQ driven, DQ_OE=1, WE_n=1.
//  WE_LO : WE_n=0 for WE_LOW_CYCLES; A/DQ held stable.
//  WE_HI : WE_n=1 for WE_HIGH_CYCLES; A/DQ held. Then next step -> SETUP. After the last step:
//   rst -> DONE, otherwise -> SETTLE.
//  SETTLE: BUSY_SETTLE cycles, FLASH_BUSY_n ignored, DQ_OE=0.
//  POLL  : timeout counter increments each cycle. FLASH_BUSY_n=1 -> DONE.
//   If count==TIMEOUT-1 with BUSY_n still 0 -> ERR_RST and error<=1. BUSY_n=1 wins a simultaneous timeout.
//  DONE  : done=1 for one cycle -> IDLE. Not entered from ERR_RST.
//  ERR_RST: issues one F0 reset cycle (SETUP/WE_LO/WE_HI timing) -> IDLE with done=0.
//  Outputs are registered. cpu_grant and cpu_wait are combinational from state and cpu_req.
//  Step and timing counters saturate-free: each is reloaded on every state entry.
// TESTING
//  1. Program 0x12345 <- 0xBEEF, WE=2/2 -> WE pulses at 555/AA, 2AA/55, 555/A0, 12345/BEEF, each 2 cycles low;
//     BUSY_n low for 50 cycles -> done 1 cycle after BUSY_n rises, busy low next.
//  2. Sector erase at 0x40000 -> 6 pulses ending 40000/0030; no BUSY sample during the 4 settle cycles.
//  3. TIMEOUT=100, BUSY_n stuck 0 -> error=1 after 100 poll cycles, one 000/F0 pulse, done never pulses;
//     next accept clears error.
//  4. cpu_req=1 with cmd_valid=1 in IDLE -> cmd_ready=0, no accept. Drop cpu_req -> accept next cycle.
//     cpu_req during POLL -> cpu_wait=1, cpu_grant=0 until IDLE.
//  5. RESET_n low during WE_LO of step 2 -> next cycle WE_n=1, DQ_OE=0, busy=0, and no further pulses.
//  6. Read-array reset op -> single 000/F0 pulse, done 1 cycle after WE_HI, no SETTLE/POLL.

Source files
------------

// File: rtl/flash_cmd_sequencer.sv
// rtl/flash_cmd_sequencer.sv - JEDEC word-mode command sequencer and flash bus arbiter
module flash_cmd_sequencer #(
    parameter int WE_LOW_CYCLES = 2,
    parameter int WE_HIGH_CYCLES = 2,
    parameter int BUSY_SETTLE = 4,
    parameter int TIMEOUT_W = 24,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT = 24'hFFFFFF
) (
    input  logic        CLKCPU,
    input  logic        RESET_n,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    input  logic [18:0] cmd_addr,
    input  logic [15:0] cmd_data,
    output logic        cmd_ready,
    output logic        busy,
    output logic        done,
    output logic        error,
    input  logic        cpu_req,
    output logic        cpu_grant,
    output logic        cpu_wait,
    input  logic        FLASH_BUSY_n,
    output logic [18:0] FLASH_A,
    output logic [15:0] FLASH_DQ_OUT,
    output logic        FLASH_DQ_OE,
    output logic        FLASH_WE_n,
    output logic        FLASH_OE_n
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SETUP   = 3'd1;
    localparam logic [2:0] WE_LO   = 3'd2;
    localparam logic [2:0] WE_HI   = 3'd3;
    localparam logic [2:0] SETTLE  = 3'd4;
    localparam logic [2:0] POLL    = 3'd5;
    localparam logic [2:0] DONE    = 3'd6;
    localparam logic [2:0] ERR_RST = 3'd7;

    localparam logic [1:0] OP_PROG  = 2'b00;
    localparam logic [1:0] OP_SECT  = 2'b01;
    localparam logic [1:0] OP_RST   = 2'b11;

    localparam logic [TIMEOUT_W-1:0] LO_LAST     = TIMEOUT_W'(WE_LOW_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] HI_LAST     = TIMEOUT_W'(WE_HIGH_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] SETTLE_LAST = TIMEOUT_W'(BUSY_SETTLE - 1);
    localparam logic [TIMEOUT_W-1:0] POLL_LAST   = TIMEOUT - TIMEOUT_W'(1);

    logic [2:0]           state, state_n;
    logic [2:0]           step, last_step;
    logic [TIMEOUT_W-1:0] cnt;
    logic [1:0]           op_r;
    logic [18:0]          addr_r;
    logic [15:0]          data_r;
    logic                 err_r;
    logic                 in_err;
    logic [18:0]          a_r;
    logic [15:0]          dq_r;
    logic                 we_n_r, dq_oe_r, busy_r, done_r;
    logic [34:0]          word_n;

    // Bus cycle {address, data} for a given command and step index.
    function automatic logic [34:0] seq_word(input logic [1:0] op, input logic [2:0] idx,
                                             input logic [18:0] a, input logic [15:0] d);
        logic [34:0] w;
        w = {19'h00000, 16'h00F0};
        if (op != OP_RST) begin
            case (idx)
                3'd0: w = {19'h00555, 16'h00AA};
                3'd1: w = {19'h002AA, 16'h0055};
                3'd2: w = (op == OP_PROG) ? {19'h00555, 16'h00A0} : {19'h00555, 16'h0080};
                3'd3: w = (op == OP_PROG) ? {a, d} : {19'h00555, 16'h00AA};
                3'd4: w = {19'h002AA, 16'h0055};
                3'd5: w = (op == OP_SECT) ? {a, 16'h0030} : {19'h00555, 16'h0010};
                default: w = {19'h00000, 16'h00F0};
            endcase
        end
        return w;
    endfunction

    // Index of the final bus cycle for the latched command.
    always_comb begin
        case (op_r)
            OP_PROG: last_step = 3'd3;
            OP_RST:  last_step = 3'd0;
            default: last_step = 3'd5;
        endcase
    end

    // Next state; the CPU wins an acceptance tie simply by blocking it.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (cmd_valid && !cpu_req) state_n = SETUP;
            SETUP:   state_n = WE_LO;
            ERR_RST: state_n = WE_LO;
            WE_LO:   if (cnt == LO_LAST) state_n = WE_HI;
            WE_HI: begin
                if (cnt == HI_LAST) begin
                    if (in_err)
                        state_n = IDLE;
                    else if (step == last_step)
                        state_n = (op_r == OP_RST) ? DONE : SETTLE;
                    else
                        state_n = SETUP;
                end
            end
            SETTLE:  if (cnt == SETTLE_LAST) state_n = POLL;
            POLL: begin
                if (FLASH_BUSY_n)
                    state_n = DONE;
                else if (cnt == POLL_LAST)
                    state_n = ERR_RST;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Address/data for the next SETUP: first cycle comes from the live command inputs.
    always_comb begin
        if (state == IDLE)
            word_n = seq_word(cmd_op, 3'd0, cmd_addr, cmd_data);
        else
            word_n = seq_word(op_r, step + 3'd1, addr_r, data_r);
    end

    // State, counters, latched command and registered pin outputs.
    always_ff @(posedge CLKCPU) begin
        if (!RESET_n) begin
            state   <= IDLE;
            step    <= 3'd0;
            cnt     <= '0;
            op_r    <= 2'b00;
            addr_r  <= 19'h0;
            data_r  <= 16'h0;
            err_r   <= 1'b0;
            in_err  <= 1'b0;
            a_r     <= 19'h0;
            dq_r    <= 16'h0;
            we_n_r  <= 1'b1;
            dq_oe_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state <= state_n;
            if (state_n != state)
                cnt <= '0;
            else if (state != IDLE)
                cnt <= cnt + 1'b1;

            if (state == IDLE)
                step <= 3'd0;
            else if (state == WE_HI && state_n == SETUP)
                step <= step + 3'd1;

            if (state == IDLE && state_n == SETUP) begin
                op_r   <= cmd_op;
                addr_r <= cmd_addr;
                data_r <= cmd_data;
                err_r  <= 1'b0;
                in_err <= 1'b0;
            end
            if (state == POLL && state_n == ERR_RST) begin
                err_r  <= 1'b1;
                in_err <= 1'b1;
            end

            if (state_n == SETUP) begin
                a_r  <= word_n[34:16];
                dq_r <= word_n[15:0];
            end else if (state_n == ERR_RST) begin
                a_r  <= 19'h0;
                dq_r <= 16'h00F0;
            end else if (state_n == IDLE) begin
                a_r  <= 19'h0;
                dq_r <= 16'h0;
            end

            we_n_r  <= (state_n != WE_LO);
            dq_oe_r <= (state_n == SETUP) || (state_n == WE_LO) ||
                       (state_n == WE_HI) || (state_n == ERR_RST);
            busy_r  <= (state_n != IDLE);
            done_r  <= (state_n == DONE);
        end
    end

    assign cmd_ready    = (state == IDLE) && !cpu_req;
    assign cpu_grant    = (state == IDLE);
    assign cpu_wait     = cpu_req && (state != IDLE);
    assign busy         = busy_r;
    assign done         = done_r;
    assign error        = err_r;
    assign FLASH_A      = a_r;
    assign FLASH_DQ_OUT = dq_r;
    assign FLASH_DQ_OE  = dq_oe_r;
    assign FLASH_WE_n   = we_n_r;
    assign FLASH_OE_n   = 1'b1;

endmodule
